alu_result_stage: RTL and testbench
===================================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of the ALU result path; only 16 is supported.
REQ-002 input_CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 input_Reset  input  1  reset, synchronous and active-high.
REQ-004 input_ALU  input  16  ALU result offered for capture.
REQ-005 input_Zero / input_Negative / input_Carry  input  1 each  ALU flags accompanying input_ALU.
REQ-006 input_Valid  input  1  producer offers {input_ALU, flags} this cycle.
REQ-007 output_Ready  output  1  stage can accept this cycle.
REQ-008 input_FlagWrite  input  1  accepted entry also updates the flag register.
REQ-009 output_ALUOut  output  16  head-entry result.
REQ-010 output_Valid  output  1  head entry present.
REQ-011 input_Ready  input  1  consumer takes the head entry this cycle.
REQ-012 output_Zero / output_Negative / output_Carry  output  1 each  architectural flag register.
REQ-013 input_BranchCond  input  3  branch condition code.
REQ-014 output_BranchTaken  output  1  condition evaluated against the flag register.

Function
REQ-015 The stage SHALL hold a 2-entry in-order buffer of {result[15:0], Z, N, C}.
REQ-016 Push: input_Valid && output_Ready; pop: output_Valid && input_Ready.
REQ-017 output_Ready SHALL be 1 whenever count < 2 (registered count, no combinational path from input_Ready).
REQ-018 Latency: an entry pushed at edge k is visible on output_ALUOut with output_Valid=1 after edge k; there is no same-cycle bypass.
REQ-019 output_ALUOut SHALL hold the last head value when output_Valid=0.
REQ-020 Simultaneous push and pop at count 1: count stays 1, and the new entry becomes head.
REQ-021 Push when full is impossible because output_Ready=0; input_Valid with output_Ready=0 is ignored and nothing is dropped or overwritten.
REQ-022 Pop when empty is ignored; count never underflows.
REQ-023 Pop at count 2 frees one slot, and output_Ready=1 on the following cycle.
REQ-024 Flag register update: on a push with input_FlagWrite=1, the flags take the input flags at that edge; otherwise they hold.
REQ-025 output_BranchTaken SHALL be combinational from the flag register and input_BranchCond:
  - 000 never, 001 always
  - 010 Z, 011 !Z
  - 100 N, 101 !N
  - 110 C, 111 !C
REQ-026 A flag write at edge k SHALL affect output_BranchTaken from cycle k+1 onward, never in the same cycle.
REQ-027 An X value on input_BranchCond SHALL drive output_BranchTaken=0.

Reset
REQ-028 While input_Reset=1 at an edge: count=0, output_Valid=0, output_ALUOut=16'h0000, flags=0.
REQ-029 During reset, output_Ready=0; it returns to 1 on the cycle after reset deasserts.
REQ-030 Reset mid-operation SHALL discard all buffered entries with no pop observed.
REQ-031 A push presented in the same cycle as reset is discarded.

Structure
REQ-032 Shared package alu_pkg SHALL define DATA_WIDTH, the branch condition codes (BR_NEVER..BR_NC), and the result-entry struct {result, Z, N, C}.
REQ-033 The buffer SHALL be sub-module result_fifo2, a 2-deep FIFO with count, head/tail pointers and valid/ready handshake.
REQ-034 Flag register and branch evaluation SHALL remain in alu_result_stage.

Verification
REQ-035 Single push: push 16'h1234 with Z=0, N=0, FlagWrite=1, input_Ready=0 -> Valid=1 and ALUOut=1234 next cycle; count=1; Ready=1.
REQ-036 Fill and stall: push 0x0001 then 0x0002 with input_Ready=0 -> Ready=0, and a third push of 0x0003 is ignored. Then pop twice -> 0001, 0002 in order, Valid=0 after.
REQ-037 Simultaneous push/pop: at count 1 (head 0x00AA), push 0x00BB and pop -> head=00BB, count stays 1.
REQ-038 Flags/branch:
  - push 0x0000 with Z=1, FlagWrite=1 -> BranchCond=010 gives Taken=1 next cycle (0 in push cycle).
  - then push 0x8000 with N=1, FlagWrite=0 -> flags unchanged, BranchCond=100 gives 0.
REQ-039 Reset mid-operation: 2 entries buffered, flags Z=1, assert reset 1 cycle -> Valid=0, ALUOut=0000, flags 0, Ready=0 during reset then 1.
REQ-040 Sweep all eight BranchCond codes over all eight flag combinations -> Taken matches REQ-025.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: data width, branch condition codes
// and the buffered result entry.
package alu_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        BR_NEVER  = 3'b000,
        BR_ALWAYS = 3'b001,
        BR_Z      = 3'b010,
        BR_NZ     = 3'b011,
        BR_N      = 3'b100,
        BR_NN     = 3'b101,
        BR_C      = 3'b110,
        BR_NC     = 3'b111
    } br_cond_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic                  z;
        logic                  n;
        logic                  c;
    } result_entry_t;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry in-order buffer of ALU result entries with a valid/ready
// handshake on both sides and a registered head result.
module result_fifo2
    import alu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  result_entry_t         wr_entry,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_result
);

    result_entry_t         mem_q [2];
    logic [1:0]            count_q;
    logic                  head_q;
    logic                  tail_q;
    logic                  run_q;
    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] next_out;
    logic                  push;
    logic                  pop;

    // run_q keeps the input side closed for the whole reset and one cycle past it
    assign wr_ready  = run_q && (count_q != 2'd2);
    assign rd_valid  = (count_q != 2'd0);
    assign rd_result = out_q;

    assign push = wr_valid && wr_ready;
    assign pop  = rd_valid && rd_ready;

    // The head result is registered so it holds its last value once the buffer drains
    always_comb begin
        next_out = out_q;
        if (pop) begin
            if (count_q == 2'd2) begin
                next_out = mem_q[~head_q].result;
            end else if (push) begin
                next_out = wr_entry.result;
            end
        end else if (count_q == 2'd0 && push) begin
            next_out = wr_entry.result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[tail_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            run_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            run_q <= 1'b1;
            out_q <= next_out;
            if (push) begin
                tail_q <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: buffers results through a 2-deep FIFO, keeps the
// architectural Z/N/C flag register and evaluates branch conditions on it.
module alu_result_stage #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  input_CLK,
    input  logic                  input_Reset,
    input  logic [DATA_WIDTH-1:0] input_ALU,
    input  logic                  input_Zero,
    input  logic                  input_Negative,
    input  logic                  input_Carry,
    input  logic                  input_Valid,
    output logic                  output_Ready,
    input  logic                  input_FlagWrite,
    output logic [DATA_WIDTH-1:0] output_ALUOut,
    output logic                  output_Valid,
    input  logic                  input_Ready,
    output logic                  output_Zero,
    output logic                  output_Negative,
    output logic                  output_Carry,
    input  logic [2:0]            input_BranchCond,
    output logic                  output_BranchTaken
);

    import alu_pkg::*;

    result_entry_t entry;
    logic          push;
    logic          flag_z_q;
    logic          flag_n_q;
    logic          flag_c_q;
    logic          taken;

    assign entry.result = input_ALU;
    assign entry.z      = input_Zero;
    assign entry.n      = input_Negative;
    assign entry.c      = input_Carry;

    result_fifo2 u_fifo (
        .clk       (input_CLK),
        .rst       (input_Reset),
        .wr_valid  (input_Valid),
        .wr_ready  (output_Ready),
        .wr_entry  (entry),
        .rd_valid  (output_Valid),
        .rd_ready  (input_Ready),
        .rd_result (output_ALUOut)
    );

    assign push = input_Valid && output_Ready;

    always_ff @(posedge input_CLK) begin
        if (input_Reset) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else if (push && input_FlagWrite) begin
            flag_z_q <= input_Zero;
            flag_n_q <= input_Negative;
            flag_c_q <= input_Carry;
        end
    end

    assign output_Zero     = flag_z_q;
    assign output_Negative = flag_n_q;
    assign output_Carry    = flag_c_q;

    // Unknown condition codes fall through to the default and never branch
    always_comb begin
        taken = 1'b0;
        case (input_BranchCond)
            BR_NEVER:  taken = 1'b0;
            BR_ALWAYS: taken = 1'b1;
            BR_Z:      taken = flag_z_q;
            BR_NZ:     taken = !flag_z_q;
            BR_N:      taken = flag_n_q;
            BR_NN:     taken = !flag_n_q;
            BR_C:      taken = flag_c_q;
            BR_NC:     taken = !flag_c_q;
            default:   taken = 1'b0;
        endcase
    end

    assign output_BranchTaken = taken;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] alu_in;
    logic        zin, nin, cin;
    logic        vin;
    logic        fw;
    logic        rdy_in;
    logic [2:0]  cond;
    logic        out_ready;
    logic [15:0] out_alu;
    logic        out_valid;
    logic        oz, on, oc;
    logic        out_taken;

    int vectors     = 0;
    int miscompares = 0;
    int checks      = 0;

    logic [15:0] model_q[$];
    bit          run      = 1'b0;
    bit          known    = 1'b0;
    logic [15:0] last_out = 16'h0000;
    bit          fz = 1'b0, fn = 1'b0, fc = 1'b0;

    always #5 clk = ~clk;

    alu_result_stage #(.DATA_WIDTH(16)) dut (
        .input_CLK          (clk),
        .input_Reset        (rst),
        .input_ALU          (alu_in),
        .input_Zero         (zin),
        .input_Negative     (nin),
        .input_Carry        (cin),
        .input_Valid        (vin),
        .output_Ready       (out_ready),
        .input_FlagWrite    (fw),
        .output_ALUOut      (out_alu),
        .output_Valid       (out_valid),
        .input_Ready        (rdy_in),
        .output_Zero        (oz),
        .output_Negative    (on),
        .output_Carry       (oc),
        .input_BranchCond   (cond),
        .output_BranchTaken (out_taken)
    );

    // Branch rule: code pairs select a flag, the low bit inverts it; pair 0 is never/always
    function automatic bit ref_taken(input logic [2:0] cc, input bit z, input bit n, input bit c);
        bit sel;
        if (cc[2:1] == 2'd0) return cc[0];
        sel = (cc[2:1] == 2'd1) ? z : (cc[2:1] == 2'd2) ? n : c;
        return sel ^ cc[0];
    endfunction

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [15:0] d, input logic z, input logic n,
                          input logic c, input logic f, input logic r, input logic [2:0] cc);
        vin = v; alu_in = d; zin = z; nin = n; cin = c; fw = f; rdy_in = r; cond = cc;
    endtask

    // One clock: check outputs mid-cycle, then advance the model across the edge
    task automatic tick();
        bit push;
        bit pop;
        @(negedge clk);
        if (known) begin
            check1("valid", out_valid, model_q.size() != 0);
            check16("aluout", out_alu, last_out);
            check1("ready", out_ready, run && (model_q.size() < 2));
            check1("flag_z", oz, fz);
            check1("flag_n", on, fn);
            check1("flag_c", oc, fc);
            check1("taken", out_taken, ref_taken(cond, fz, fn, fc));
        end
        push = vin && run && (model_q.size() < 2);
        pop  = (model_q.size() != 0) && rdy_in;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            run      = 1'b0;
            last_out = 16'h0000;
            fz = 1'b0; fn = 1'b0; fc = 1'b0;
            known    = 1'b1;
        end else begin
            if (pop) void'(model_q.pop_front());
            if (push) model_q.push_back(alu_in);
            if (push && fw) begin
                fz = zin; fn = nin; fc = cin;
            end
            run = 1'b1;
            if (model_q.size() != 0) last_out = model_q[0];
        end
        vectors++;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_in(1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b001);
        tick();
        tick();
        check1("rst_ready", out_ready, 1'b0);
        check1("rst_valid", out_valid, 1'b0);
        check16("rst_aluout", out_alu, 16'h0000);
        check1("rst_flag_z", oz, 1'b0);

        rst = 1'b0;
        set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        check1("ready_after_rst", out_ready, 1'b1);

        // Single push
        set_in(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
        tick();
        vin = 1'b0;
        check1("single_valid", out_valid, 1'b1);
        check16("single_aluout", out_alu, 16'h1234);
        check1("single_ready", out_ready, 1'b1);
        rdy_in = 1'b1;
        tick();
        rdy_in = 1'b0;

        // Fill, stall, drain in order
        set_in(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        alu_in = 16'h0002;
        tick();
        check1("full_ready", out_ready, 1'b0);
        alu_in = 16'h0003;
        tick();
        vin = 1'b0;
        check16("full_head", out_alu, 16'h0001);
        rdy_in = 1'b1;
        tick();
        check16("pop1", out_alu, 16'h0002);
        check1("pop1_ready", out_ready, 1'b1);
        tick();
        check1("drained_valid", out_valid, 1'b0);
        check16("drained_hold", out_alu, 16'h0002);
        tick();
        check16("empty_pop_hold", out_alu, 16'h0002);

        // Simultaneous push/pop at count 1
        set_in(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        set_in(1'b1, 16'h00BB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
        tick();
        check16("pushpop_head", out_alu, 16'h00BB);
        check1("pushpop_ready", out_ready, 1'b1);
        set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
        tick();
        check1("pushpop_drained", out_valid, 1'b0);

        // Flag write timing and FlagWrite gating
        set_in(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010);
        #1;
        check1("z_same_cycle", out_taken, 1'b0);
        tick();
        check1("z_next_cycle", out_taken, 1'b1);
        set_in(1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100);
        tick();
        vin = 1'b0;
        check1("n_not_written", out_taken, 1'b0);
        check1("z_held", oz, 1'b1);

        // Reset with two entries buffered
        rst = 1'b1;
        tick();
        check1("midrst_valid", out_valid, 1'b0);
        check16("midrst_aluout", out_alu, 16'h0000);
        check1("midrst_flag_z", oz, 1'b0);
        check1("midrst_ready", out_ready, 1'b0);
        rst = 1'b0;
        tick();
        check1("post_rst_ready", out_ready, 1'b1);
        check1("post_rst_valid", out_valid, 1'b0);

        // Every condition code against every flag combination
        for (int f = 0; f < 8; f++) begin
            set_in(1'b1, 16'(f), f[2], f[1], f[0], 1'b1, 1'b1, 3'b000);
            tick();
            vin = 1'b0;
            for (int c = 0; c < 8; c++) begin
                cond = 3'(c);
                tick();
            end
        end

        // Random traffic with occasional reset
        for (int i = 0; i < 500; i++) begin
            rst    = ($urandom_range(0, 39) == 0);
            vin    = 1'($urandom_range(0, 1));
            alu_in = 16'($urandom);
            zin    = 1'($urandom_range(0, 1));
            nin    = 1'($urandom_range(0, 1));
            cin    = 1'($urandom_range(0, 1));
            fw     = 1'($urandom_range(0, 1));
            rdy_in = ($urandom_range(0, 2) != 0);
            cond   = 3'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
